// File: rtl/core85_pkg.sv
// core85_pkg: shared definitions for the 8085-style bus sequencer.
// Cycle codes, one-hot T-states, bit indices and status triplets.
package core85_pkg;

    // Machine-cycle type as delivered by the decoder.
    typedef enum logic [2:0] {
        CY_OF   = 3'd0,
        CY_MR   = 3'd1,
        CY_MW   = 3'd2,
        CY_IOR  = 3'd3,
        CY_IOW  = 3'd4,
        CY_INA  = 3'd5,
        CY_BI   = 3'd6,
        CY_HALT = 3'd7
    } cyc_t;

    // Bit positions of each T-state in the one-hot tstate bus.
    localparam int TSB_TR = 0;
    localparam int TSB_T1 = 1;
    localparam int TSB_T2 = 2;
    localparam int TSB_T3 = 3;
    localparam int TSB_T4 = 4;
    localparam int TSB_T5 = 5;
    localparam int TSB_T6 = 6;
    localparam int TSB_TH = 7;
    localparam int TSB_TW = 8;
    localparam int TSB_TT = 9;
    localparam int TSB_TI = 10;

    localparam int TS_W = 11;

    // One-hot encoding; the state register is the tstate output.
    typedef enum logic [TS_W-1:0] {
        TS_TR = 11'b000_0000_0001,
        TS_T1 = 11'b000_0000_0010,
        TS_T2 = 11'b000_0000_0100,
        TS_T3 = 11'b000_0000_1000,
        TS_T4 = 11'b000_0001_0000,
        TS_T5 = 11'b000_0010_0000,
        TS_T6 = 11'b000_0100_0000,
        TS_TH = 11'b000_1000_0000,
        TS_TW = 11'b001_0000_0000,
        TS_TT = 11'b010_0000_0000,
        TS_TI = 11'b100_0000_0000
    } tstate_t;

    // Status triplet {iom_, s1, s0} for each cycle type.
    function automatic logic [2:0] status_of(input cyc_t c);
        logic [2:0] s;
        unique case (c)
            CY_OF:   s = 3'b011;
            CY_MR:   s = 3'b010;
            CY_MW:   s = 3'b001;
            CY_IOR:  s = 3'b110;
            CY_IOW:  s = 3'b101;
            CY_INA:  s = 3'b111;
            CY_BI:   s = 3'b010;
            CY_HALT: s = 3'b000;
            default: s = 3'b000;
        endcase
        return s;
    endfunction

    // Cycles that pull rd_ low and sample the data bus.
    function automatic logic is_rd(input cyc_t c);
        return (c == CY_OF) || (c == CY_MR) || (c == CY_IOR);
    endfunction

    // Cycles that drive data and pull wr_ low.
    function automatic logic is_wr(input cyc_t c);
        return (c == CY_MW) || (c == CY_IOW);
    endfunction

endpackage

// File: rtl/bcs_wait_counter.sv
// bcs_wait_counter: per-cycle internal wait-state counter.
// Loads desc_wait + AUTO_WAIT (saturating), counts down in TW.
module bcs_wait_counter #(
    parameter int WCNT_W    = 3,
    parameter int AUTO_WAIT = 0
) (
    input  logic              clk_,
    input  logic              rst_,
    input  logic              i_load,
    input  logic [WCNT_W-1:0] i_wait,
    input  logic              i_dec,
    output logic              o_zero,
    output logic              o_last
);

    localparam logic [WCNT_W-1:0] AW = WCNT_W'(AUTO_WAIT);
    localparam logic [WCNT_W-1:0] ONE = WCNT_W'(1);

    logic [WCNT_W-1:0] r_cnt;
    logic [WCNT_W:0]   w_sum;
    logic [WCNT_W-1:0] w_ld;

    // Saturating load value: all-ones when the sum overflows.
    always_comb begin
        w_sum = {1'b0, i_wait} + {1'b0, AW};
        w_ld  = w_sum[WCNT_W] ? '1 : w_sum[WCNT_W-1:0];
    end

    // Load on descriptor accept, otherwise decrement toward zero.
    always_ff @(posedge clk_ or posedge rst_) begin
        if (rst_) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= w_ld;
        end else if (i_dec && !o_zero) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    // o_last: this TW clock uses up the final programmed wait.
    assign o_zero = (r_cnt == '0);
    assign o_last = o_zero || (r_cnt == ONE);

endmodule

// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer: 8085-style T-state sequencer, one machine
// cycle per accepted descriptor, with waits, HOLD and halt exit.
module bus_cycle_sequencer
    import core85_pkg::*;
#(
    parameter int WCNT_W     = 3,
    parameter int AUTO_WAIT  = 0,
    parameter int OF_LONG_EN = 1
) (
    input  logic              clk_,
    input  logic              rst_,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [2:0]        desc_type,
    input  logic              desc_long,
    input  logic [WCNT_W-1:0] desc_wait,
    input  logic              ready,
    input  logic              hold,
    input  logic              intr_req,
    output logic              hlda,
    output logic              ale,
    output logic              rd_,
    output logic              wr_,
    output logic              inta_,
    output logic              iom_,
    output logic              s1,
    output logic              s0,
    output logic              addr_oe,
    output logic              data_oe,
    output logic              ctl_oe,
    output logic [10:0]       tstate,
    output logic              rd_strobe,
    output logic              cyc_done
);

    tstate_t r_state;
    tstate_t w_nxt;
    cyc_t    r_type;
    logic    r_long;
    logic    r_halted;

    logic    w_bnd;
    logic    w_accept;
    logic    w_set_halt;
    logic    w_clr_halt;
    logic    w_dec;
    logic    w_zero;
    logic    w_last;
    logic    w_long;
    logic    w_rd;
    logic    w_wr;
    logic [2:0] w_stat;

    assign w_long = r_long && (OF_LONG_EN != 0);
    assign w_rd   = is_rd(r_type);
    assign w_wr   = is_wr(r_type);
    assign w_stat = status_of(r_type);

    // Ready only where T1 may follow; reset forces it low.
    assign desc_ready = w_bnd && !hold && !rst_;
    assign w_accept   = desc_ready && desc_valid;

    assign tstate = r_state;

    bcs_wait_counter #(
        .WCNT_W    (WCNT_W),
        .AUTO_WAIT (AUTO_WAIT)
    ) u_wcnt (
        .clk_   (clk_),
        .rst_   (rst_),
        .i_load (w_accept),
        .i_wait (desc_wait),
        .i_dec  (w_dec),
        .o_zero (w_zero),
        .o_last (w_last)
    );

    // State register; async reset returns to TR and floats the bus.
    always_ff @(posedge clk_ or posedge rst_) begin
        if (rst_) begin
            r_state <= TS_TR;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Descriptor latch and halted flag.
    always_ff @(posedge clk_ or posedge rst_) begin
        if (rst_) begin
            r_type   <= CY_OF;
            r_long   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            if (w_accept) begin
                r_type <= cyc_t'(desc_type);
                r_long <= desc_long;
            end
            if (w_set_halt) begin
                r_halted <= 1'b1;
            end else if (w_clr_halt) begin
                r_halted <= 1'b0;
            end
        end
    end

    // Next-state and per-T-state bus outputs.
    always_comb begin
        w_nxt      = r_state;
        w_bnd      = 1'b0;
        w_set_halt = 1'b0;
        w_clr_halt = 1'b0;
        w_dec      = 1'b0;
        hlda       = 1'b0;
        ale        = 1'b0;
        rd_        = 1'b1;
        wr_        = 1'b1;
        inta_      = 1'b1;
        iom_       = 1'b0;
        s1         = 1'b0;
        s0         = 1'b0;
        addr_oe    = 1'b0;
        data_oe    = 1'b0;
        ctl_oe     = 1'b0;
        rd_strobe  = 1'b0;
        cyc_done   = 1'b0;

        unique case (r_state)
            TS_TR: begin
                w_bnd = 1'b1;
            end
            TS_TI: begin
                ctl_oe = 1'b1;
                w_bnd  = 1'b1;
            end
            TS_T1: begin
                ale = (r_type != CY_BI) && (r_type != CY_HALT);
                {iom_, s1, s0} = w_stat;
                addr_oe = 1'b1;
                ctl_oe  = 1'b1;
                if (r_type == CY_HALT) begin
                    w_nxt      = TS_TT;
                    w_set_halt = 1'b1;
                end else begin
                    w_nxt = TS_T2;
                end
            end
            TS_T2: begin
                {iom_, s1, s0} = w_stat;
                addr_oe = 1'b1;
                ctl_oe  = 1'b1;
                data_oe = w_wr;
                rd_     = !w_rd;
                wr_     = !w_wr;
                inta_   = (r_type != CY_INA);
                if (!w_zero || (!ready && r_type != CY_BI)) begin
                    w_nxt = TS_TW;
                end else begin
                    w_nxt = TS_T3;
                end
            end
            TS_TW: begin
                {iom_, s1, s0} = w_stat;
                addr_oe = 1'b1;
                ctl_oe  = 1'b1;
                data_oe = w_wr;
                rd_     = !w_rd;
                wr_     = !w_wr;
                inta_   = (r_type != CY_INA);
                w_dec   = 1'b1;
                if (w_last && (ready || r_type == CY_BI)) begin
                    w_nxt = TS_T3;
                end
            end
            TS_T3: begin
                {iom_, s1, s0} = w_stat;
                addr_oe   = 1'b1;
                ctl_oe    = 1'b1;
                data_oe   = w_wr;
                rd_       = !w_rd;
                wr_       = !w_wr;
                inta_     = (r_type != CY_INA);
                rd_strobe = w_rd || (r_type == CY_INA);
                if (r_type == CY_OF) begin
                    w_nxt = TS_T4;
                end else begin
                    cyc_done = 1'b1;
                    w_bnd    = 1'b1;
                end
            end
            TS_T4: begin
                {iom_, s1, s0} = 3'b011;
                ctl_oe = 1'b1;
                if (w_long) begin
                    w_nxt = TS_T5;
                end else begin
                    cyc_done = 1'b1;
                    w_bnd    = 1'b1;
                end
            end
            TS_T5: begin
                {iom_, s1, s0} = 3'b011;
                ctl_oe = 1'b1;
                w_nxt  = TS_T6;
            end
            TS_T6: begin
                {iom_, s1, s0} = 3'b011;
                ctl_oe   = 1'b1;
                cyc_done = 1'b1;
                w_bnd    = 1'b1;
            end
            TS_TH: begin
                hlda = 1'b1;
                if (!hold) begin
                    if (r_halted) begin
                        w_nxt = TS_TT;
                    end else begin
                        w_bnd = 1'b1;
                    end
                end
            end
            TS_TT: begin
                if (hold) begin
                    w_nxt = TS_TH;
                end else if (intr_req) begin
                    w_clr_halt = 1'b1;
                    w_bnd      = 1'b1;
                end
            end
            default: begin
                w_nxt = TS_TR;
            end
        endcase

        // Cycle boundary: HOLD first, then a new cycle, else idle.
        if (w_bnd) begin
            if (hold) begin
                w_nxt = TS_TH;
            end else if (desc_valid) begin
                w_nxt = TS_T1;
            end else begin
                w_nxt = TS_TI;
            end
        end
    end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// tb_bus_cycle_sequencer: directed test-plan scenarios then random
// traffic, every clock compared with a T-state reference model.
module tb_bus_cycle_sequencer;

    localparam int WCNT_W = 3;
    localparam int AW     = 0;
    localparam int OFL    = 1;
    localparam int WMAX   = (1 << WCNT_W) - 1;

    localparam int S_TR = 0;
    localparam int S_T1 = 1;
    localparam int S_T2 = 2;
    localparam int S_T3 = 3;
    localparam int S_T4 = 4;
    localparam int S_T5 = 5;
    localparam int S_T6 = 6;
    localparam int S_TH = 7;
    localparam int S_TW = 8;
    localparam int S_TT = 9;
    localparam int S_TI = 10;

    logic              clk_;
    logic              rst_;
    logic              desc_valid;
    logic              desc_ready;
    logic [2:0]        desc_type;
    logic              desc_long;
    logic [WCNT_W-1:0] desc_wait;
    logic              ready;
    logic              hold;
    logic              intr_req;
    logic              hlda;
    logic              ale;
    logic              rd_;
    logic              wr_;
    logic              inta_;
    logic              iom_;
    logic              s1;
    logic              s0;
    logic              addr_oe;
    logic              data_oe;
    logic              ctl_oe;
    logic [10:0]       tstate;
    logic              rd_strobe;
    logic              cyc_done;

    bus_cycle_sequencer #(
        .WCNT_W     (WCNT_W),
        .AUTO_WAIT  (AW),
        .OF_LONG_EN (OFL)
    ) dut (
        .clk_       (clk_),
        .rst_       (rst_),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_type  (desc_type),
        .desc_long  (desc_long),
        .desc_wait  (desc_wait),
        .ready      (ready),
        .hold       (hold),
        .intr_req   (intr_req),
        .hlda       (hlda),
        .ale        (ale),
        .rd_        (rd_),
        .wr_        (wr_),
        .inta_      (inta_),
        .iom_       (iom_),
        .s1         (s1),
        .s0         (s0),
        .addr_oe    (addr_oe),
        .data_oe    (data_oe),
        .ctl_oe     (ctl_oe),
        .tstate     (tstate),
        .rd_strobe  (rd_strobe),
        .cyc_done   (cyc_done)
    );

    initial begin
        clk_ = 1'b0;
        forever #5 clk_ = ~clk_;
    end

    int checks   = 0;
    int failures = 0;
    int n_tw     = 0;

    // Reference model: current T-state label, latched cycle info,
    // waits required and TW clocks already spent in this cycle.
    int ms, mt, ml, mneed, mk, mhalt;
    int n_ms, n_mt, n_ml, n_need, n_k, n_halt;
    logic [10:0] e_ts;
    logic [13:0] e_out;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [2:0] stat_of(input int t);
        case (t)
            0: return 3'b011;
            1: return 3'b010;
            2: return 3'b001;
            3: return 3'b110;
            4: return 3'b101;
            5: return 3'b111;
            6: return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    task automatic m_reset();
        ms = S_TR; mt = 0; ml = 0; mneed = 0; mk = 0; mhalt = 0;
    endtask

    task automatic m_eval();
        logic bnd, dr, hl, al, rdn, wrn, itn, ao, dq, co, rs, dn;
        logic [2:0] st;
        int t;
        logic rdt, wrt, lng;
        t   = mt;
        rdt = (t == 0) || (t == 1) || (t == 3);
        wrt = (t == 2) || (t == 4);
        lng = (ml != 0) && (OFL != 0);
        bnd = 0; hl = 0; al = 0; rdn = 1; wrn = 1; itn = 1;
        ao = 0; dq = 0; co = 0; rs = 0; dn = 0; st = 3'b000;
        n_ms = ms; n_mt = mt; n_ml = ml; n_need = mneed;
        n_k = mk; n_halt = mhalt;
        case (ms)
            S_TR: bnd = 1;
            S_TI: begin bnd = 1; co = 1; end
            S_T1: begin
                al = (t != 6) && (t != 7);
                st = stat_of(t); ao = 1; co = 1;
                if (t == 7) begin n_ms = S_TT; n_halt = 1; end
                else begin n_ms = S_T2; n_k = 0; end
            end
            S_T2, S_TW, S_T3: begin
                st = stat_of(t); ao = 1; co = 1;
                rdn = !rdt; wrn = !wrt; itn = (t != 5); dq = wrt;
                if (ms == S_T3) begin
                    rs = rdt || (t == 5);
                    if (t == 0) n_ms = S_T4;
                    else begin dn = 1; bnd = 1; end
                end else if (mk >= mneed && (ready || t == 6)) begin
                    n_ms = S_T3;
                end else begin
                    n_ms = S_TW; n_k = mk + 1;
                end
            end
            S_T4: begin
                st = 3'b011; co = 1;
                if (lng) n_ms = S_T5;
                else begin dn = 1; bnd = 1; end
            end
            S_T5: begin st = 3'b011; co = 1; n_ms = S_T6; end
            S_T6: begin st = 3'b011; co = 1; dn = 1; bnd = 1; end
            S_TH: begin
                hl = 1;
                if (!hold) begin
                    if (mhalt != 0) n_ms = S_TT;
                    else bnd = 1;
                end
            end
            S_TT: begin
                if (hold) n_ms = S_TH;
                else if (intr_req) begin n_halt = 0; bnd = 1; end
            end
            default: ;
        endcase
        if (bnd) begin
            if (hold) n_ms = S_TH;
            else if (desc_valid) begin
                n_ms = S_T1; n_mt = int'(desc_type);
                n_ml = int'(desc_long);
                n_need = int'(desc_wait) + AW;
                if (n_need > WMAX) n_need = WMAX;
            end else n_ms = S_TI;
        end
        dr = bnd && !hold && !rst_;
        e_ts  = 11'b1 << ms;
        e_out = {dr, hl, al, rdn, wrn, itn, st, ao, dq, co, rs, dn};
    endtask

    // One clock: check away from the edge, then advance the model.
    task automatic tick();
        #1;
        if (rst_) m_reset();
        m_eval();
        chk("tstate", tstate, e_ts);
        chk("outs", {desc_ready, hlda, ale, rd_, wr_, inta_, iom_, s1, s0,
                     addr_oe, data_oe, ctl_oe, rd_strobe, cyc_done}, e_out);
        if (tstate[S_TW]) n_tw++;
        @(posedge clk_);
        if (!rst_) begin
            ms = n_ms; mt = n_mt; ml = n_ml; mneed = n_need;
            mk = n_k; mhalt = n_halt;
        end
        @(negedge clk_);
    endtask

    task automatic set_in(input logic v, input int ty, input logic lg,
                          input int w, input logic rdy, input logic hd,
                          input logic irq);
        desc_valid = v;
        desc_type  = 3'(ty);
        desc_long  = lg;
        desc_wait  = WCNT_W'(w);
        ready      = rdy;
        hold       = hd;
        intr_req   = irq;
    endtask

    initial begin
        rst_ = 1'b1;
        m_reset();
        set_in(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk_);
        tick();
        tick();

        // OF short from reset release.
        rst_ = 1'b0;
        set_in(1, 0, 0, 0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0);
        repeat (5) tick();

        // MR with two programmed waits.
        set_in(1, 1, 0, 2, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0);
        n_tw = 0;
        repeat (6) tick();
        chk("mr_tw_count", n_tw, 2);

        // MW with READY low for three clocks from T2.
        set_in(1, 2, 0, 0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0);
        n_tw = 0;
        tick();
        ready = 1'b0;
        repeat (3) tick();
        ready = 1'b1;
        repeat (3) tick();
        chk("mw_tw_count", n_tw, 3);

        // HOLD raised in T2 of MR, taken at the boundary.
        set_in(1, 1, 0, 0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0);
        tick();
        hold = 1'b1;
        repeat (4) tick();
        set_in(1, 0, 0, 0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0);
        repeat (5) tick();

        // HALT, a HOLD excursion, then interrupt exit.
        set_in(1, 7, 0, 0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0);
        repeat (2) tick();
        hold = 1'b1;
        repeat (2) tick();
        hold = 1'b0;
        repeat (2) tick();
        set_in(1, 1, 0, 0, 1, 0, 1);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0);
        repeat (6) tick();

        // Long OF, idle, then a new descriptor.
        set_in(1, 0, 1, 0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0);
        repeat (10) tick();
        set_in(1, 1, 0, 0, 1, 0, 0);
        tick();

        // Asynchronous reset in the middle of a read strobe.
        set_in(0, 0, 0, 0, 1, 0, 0);
        tick();
        rst_ = 1'b1;
        tick();
        rst_ = 1'b0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_ = ($urandom_range(0, 249) == 0);
            set_in($urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 7)),
                   $urandom_range(0, 1) == 1,
                   ($urandom_range(0, 3) == 0) ?
                       int'($urandom_range(0, WMAX)) :
                       int'($urandom_range(0, 1)),
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 9) == 0,
                   $urandom_range(0, 3) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_cycle_sequencer.md
Name: bus_cycle_sequencer

Overview:
Parametrised successor to the core machine-cycle controller. Sequences 8085-style T-states (T1..T6, TW, TH, TT) for one machine cycle per accepted descriptor. Adds programmable internal wait states, a valid/ready descriptor handshake with idle insertion, HOLD/HLDA arbitration and interrupt exit from halt. Sits between the instruction decoder (descriptor source) and the pin/bus-driver logic.

Parameters:
WCNT_W, 3, width of per-cycle internal wait count.
AUTO_WAIT, 0, minimum wait states added to every non-idle cycle (0..2^WCNT_W-1).
OF_LONG_EN, 1, allow 6-T opcode fetch (1) or force 4-T (0).

Ports:
clk_  in  1  clock.
rst_  in  1  reset.
desc_valid  in  1  descriptor available.
desc_ready  out  1  descriptor accepted this clock when valid & ready.
desc_type  in  3  cycle: 0 OF, 1 MR, 2 MW, 3 IOR, 4 IOW, 5 INA, 6 BI (bus idle), 7 HALT.
desc_long  in  1  OF uses T5/T6.
desc_wait  in  WCNT_W  extra internal waits for this cycle.
ready  in  1  external READY.
hold  in  1  external HOLD.
intr_req  in  1  pending enabled interrupt (halt exit).
hlda  out  1  hold acknowledge.
ale  out  1  address latch enable.
rd_, wr_, inta_  out  1 each  active-low strobes.
iom_, s1, s0  out  1 each  status.
addr_oe, data_oe, ctl_oe  out  1 each  bus driver enables.
tstate  out  11  one-hot {TI,TT,TW,TH,T6,T5,T4,T3,T2,T1,TR}.
rd_strobe  out  1  sample data bus (last clock of T3, read/OF/INA).
cyc_done  out  1  one-clock pulse, final T-state of a cycle.

Behaviour:
- Reset rst_, asynchronous, active-high; clock clk_. All state on posedge clk_.
- Reset values: tstate=TR, desc_ready=0, hlda=0, ale=0, rd_/wr_/inta_=1, iom_/s1/s0=0, all *_oe=0, rd_strobe=0, cyc_done=0, wait counter=0, halted=0.
- desc_ready=1 only in the clock before T1 could be entered: TR, TI, last T-state of a cycle (T3 non-OF, T4 short OF, T6), and TH/TT exit clocks. It is forced 0 when hold=1 or halted=1 and intr_req=0.
- Boundary: hold=1 -> TH. Else valid -> T1 with descriptor latched (type, long, wcnt=desc_wait+AUTO_WAIT, saturating at 2^WCNT_W-1). Else -> TI.
- TI: bus idle, all strobes high, ctl_oe=1, addr_oe=0. Boundary rule re-evaluated every clock.
- T1: ale=1 except BI/HALT. Status driven from latched type: OF 011, MR 010, MW 001, IOR 110, IOW 101, INA 111, BI 010, HALT 000 as {iom_,s1,s0}. addr_oe=ctl_oe=1. HALT -> TT next (halted=1); others -> T2.
- T2: strobe asserted per type (rd_ for OF/MR/IOR; wr_ for MW/IOW; inta_ for INA; none for BI). data_oe=1 for MW/IOW only. -> TW if wcnt!=0 or (ready=0 and type!=BI), else T3.
- TW: same outputs as T2. wcnt decrements if nonzero. -> T3 when wcnt==0 and ready=1 (BI ignores ready).
- T3: strobes held; rd_strobe=1 for OF/MR/IOR/INA. OF -> T4. Others: cyc_done=1, then boundary rule.
- T4: strobes high, addr_oe=0, data_oe=0, s1=s0=1 (OF status held). Long (desc_long & OF_LONG_EN) -> T5. Else cyc_done=1, boundary rule.
- T5 -> T6. T6: cyc_done=1, boundary rule.
- TH: hlda=1, addr_oe=data_oe=ctl_oe=0. On hold=0: -> TT if halted, else boundary rule. hlda drops the clock TH is left.
- TT: bus floated as TH with hlda=0. Priority: hold=1 -> TH; intr_req=1 -> halted=0, boundary rule; else stay.
- hold asserted mid-cycle does not abort the cycle; it is taken at the next boundary. ready is ignored outside T2/TW.
- rst_ mid-cycle drops strobes to their inactive level immediately (async).

Decomposition:
- Shared package core85_pkg: cycle-type codes, one-hot T-state constants, status triplet per type, tstate bit indices.
- One sub-module: bcs_wait_counter (load/saturate/decrement/zero flag, WCNT_W wide).

Test Plan:
- Reset release, desc OF short, wait=0, ready=1 -> TR,T1,T2,T3,T4. ale only in T1, rd_ low T2-T3, cyc_done at T4, status 011.
- MR with desc_wait=2, AUTO_WAIT=0, ready=1 -> T1,T2,TW,TW,T3. rd_strobe in T3 only.
- MW, ready low 3 clocks from T2 -> exactly 3 TW. data_oe and wr_ low T2 through T3.
- hold raised during T2 of MR -> cycle completes, TH next clock, hlda=1, oe all 0. hold drop -> T1 of next valid descriptor.
- HALT descriptor, then hold pulse, then intr_req=1 -> T1,TT,TH,TT, then T1 with desc_ready=1 on exit.
- desc_valid=0 after OF long -> T6 then TI repeated. desc_valid rises -> T1 next clock.
